reg_funsel_sequencer: RTL and testbench

Command-driven controller that issues FunSel/E operations to a bank of four 16-bit FunSel registers (decrement/increment/load/clear type). It accepts one command at a time over a valid/ready handshake and expands it into one or more single-cycle register operations. In the datapath it sits between the control unit and the register bank, driving the shared FunSel and I buses and one E line per register. An optional shadow copy of each register lets the control unit read back values without a datapath mux.

---
 rtl/reg_funsel_sequencer.sv | 142 ++++++++++++++
 tb/tb_reg_funsel_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_funsel_sequencer.sv
// reg_funsel_sequencer
// Accepts one command at a time over a valid/ready handshake and expands it into
// single-cycle FunSel/E operations on a bank of four FunSel registers.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   CmdValid/CmdReady    command handshake
//   CmdOp                00 DEC, 01 INC, 10 LOAD, 11 CLEAR
//   CmdSel               target register 0..3
//   CmdCount             repeat count for DEC/INC (ops issued = CmdCount+1)
//   CmdData              LOAD immediate
//   E, FunSel, I         one-hot enables and shared buses to the register bank
//   Done                 one-cycle pulse after the last issued op
//   ReadSel/ReadQ        combinational shadow readback
//   ShadowValid          per-register flag: shadow set by LOAD/CLEAR since reset
//
// Optional feature: define REG_SEQ_SHADOW_EN to build the shadow registers.
// Without it ReadQ and ShadowValid are tied to zero.
module reg_funsel_sequencer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [1:0]        CmdOp,
  input  logic [1:0]        CmdSel,
  input  logic [3:0]        CmdCount,
  input  logic [DATA_W-1:0] CmdData,
  output logic [3:0]        E,
  output logic [1:0]        FunSel,
  output logic [DATA_W-1:0] I,
  output logic              Done,
  input  logic [1:0]        ReadSel,
  output logic [DATA_W-1:0] ReadQ,
  output logic [3:0]        ShadowValid
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        remaining_q, remaining_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sel_d       = sel_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    CmdReady    = 1'b0;
    E           = 4'b0000;
    unique case (state_q)
      StIdle: begin
        CmdReady = ~Reset;
        if (CmdValid) begin
          op_d        = CmdOp;
          sel_d       = CmdSel;
          data_d      = CmdData;
          // LOAD/CLEAR (op[1]=1) always issue exactly one op
          remaining_d = CmdOp[1] ? 4'd0 : CmdCount;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Gate E with Reset so no op reaches the bank on a reset edge
        E = Reset ? 4'b0000 : (4'b0001 << sel_q);
        if (remaining_q == 4'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          remaining_d = remaining_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      sel_q       <= 2'b00;
      data_q      <= '0;
      remaining_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Buses hold the last latched command outside ISSUE; the bank ignores them while E=0
  assign FunSel = op_q;
  assign I      = data_q;
  assign Done   = done_q;

`ifdef REG_SEQ_SHADOW_EN
  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] shadow_q [4];
  logic [3:0]        valid_q;

  // Mirrors the register bank: same op, same edge, modulo 2^DATA_W
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) shadow_q[k] <= '0;
      valid_q <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (E[k]) begin
          unique case (op_q)
            2'b00: shadow_q[k] <= shadow_q[k] - One;
            2'b01: shadow_q[k] <= shadow_q[k] + One;
            2'b10: shadow_q[k] <= data_q;
            2'b11: shadow_q[k] <= '0;
            default: shadow_q[k] <= shadow_q[k];
          endcase
          if (op_q[1]) valid_q[k] <= 1'b1;
        end
      end
    end
  end

  assign ReadQ       = shadow_q[ReadSel];
  assign ShadowValid = valid_q;
`else
  logic unused_readsel;
  assign unused_readsel = ^ReadSel;
  assign ReadQ          = '0;
  assign ShadowValid    = 4'b0000;
`endif

endmodule

// File: tb/tb_reg_funsel_sequencer.sv
// Scoreboard bench for reg_funsel_sequencer: stimulus pushes expected ops and
// completion snapshots computed arithmetically; a monitor pops and compares.
module tb_reg_funsel_sequencer;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [1:0]  CmdOp = 2'b00;
  logic [1:0]  CmdSel = 2'b00;
  logic [3:0]  CmdCount = 4'd0;
  logic [15:0] CmdData = 16'h0;
  logic [3:0]  E;
  logic [1:0]  FunSel;
  logic [15:0] I;
  logic        Done;
  logic [1:0]  ReadSel = 2'b00;
  logic [15:0] ReadQ;
  logic [3:0]  ShadowValid;

  reg_funsel_sequencer #(.DATA_W(16)) dut (
    .Clock(clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdSel(CmdSel), .CmdCount(CmdCount), .CmdData(CmdData),
    .E(E), .FunSel(FunSel), .I(I), .Done(Done),
    .ReadSel(ReadSel), .ReadQ(ReadQ), .ShadowValid(ShadowValid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [3:0]  e;
    logic [1:0]  fs;
    logic [15:0] i;
  } op_t;

  typedef struct {
    int               cyc;
    logic [3:0][15:0] r;
    logic [3:0]       v;
  } done_t;

  op_t   op_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0][15:0] m_reg = '0;
  logic [3:0]       m_vld = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: compares every issued op and every Done against the scoreboard
  initial forever begin
    op_t   eo;
    done_t ed;
    @(negedge clock);
    if (E !== 4'b0000) begin
      chk("ready_low_in_issue", {31'b0, CmdReady}, 32'd0);
      if (op_q.size() == 0) begin
        chk("unexpected_E", {28'b0, E}, 32'd0);
      end else begin
        eo = op_q.pop_front();
        chk("op_cycle", eo.cyc, cyc);
        chk("op_E", {28'b0, E}, {28'b0, eo.e});
        chk("op_FunSel", {30'b0, FunSel}, {30'b0, eo.fs});
        chk("op_I", {16'b0, I}, {16'b0, eo.i});
      end
    end
    if (Done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_Done", 32'd1, 32'd0);
      end else begin
        ed = done_q.pop_front();
        chk("done_cycle", ed.cyc, cyc);
        chk("done_ready", {31'b0, CmdReady}, 32'd1);
`ifdef REG_SEQ_SHADOW_EN
        chk("shadow_valid", {28'b0, ShadowValid}, {28'b0, ed.v});
`else
        chk("shadow_valid_off", {28'b0, ShadowValid}, 32'd0);
`endif
        for (int k = 0; k < 4; k++) begin
          ReadSel = 2'(k);
          #1;
`ifdef REG_SEQ_SHADOW_EN
          chk($sformatf("readq_%0d", k), {16'b0, ReadQ}, {16'b0, ed.r[k]});
`else
          chk($sformatf("readq_off_%0d", k), {16'b0, ReadQ}, 32'd0);
`endif
        end
      end
    end
  end

  // Issues one command; abort_ops>=0 means only that many ops are expected and
  // the model is not updated (caller resets mid-command).
  task automatic send(input logic [1:0] op, input logic [1:0] sel, input logic [3:0] cnt,
                      input logic [15:0] d, input int abort_ops, output int acc);
    logic rdy;
    int   guard;
    int   n;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdSel   = sel;
    CmdCount = cnt;
    CmdData  = d;
    guard    = 0;
    do begin
      @(negedge clock);
      rdy = CmdReady;
      @(posedge clock);
      guard++;
    end while (!rdy && guard < 100);
    #1;
    acc = cyc;
    if (!rdy) begin
      chk("accept_timeout", 32'd0, 32'd1);
      CmdValid = 1'b0;
      return;
    end
    // Scramble operands so any post-accept sampling would be visible
    CmdValid = 1'b0;
    CmdOp    = 2'($urandom);
    CmdSel   = 2'($urandom);
    CmdCount = 4'($urandom);
    CmdData  = 16'($urandom);
    n = op[1] ? 0 : int'(cnt);
    if (abort_ops >= 0) n = abort_ops - 1;
    for (int j = 0; j <= n; j++) op_q.push_back('{acc + j, 4'(1) << sel, op, d});
    if (abort_ops < 0) begin
      case (op)
        2'b00: m_reg[sel] = m_reg[sel] - 16'(n + 1);
        2'b01: m_reg[sel] = m_reg[sel] + 16'(n + 1);
        2'b10: begin m_reg[sel] = d;     m_vld[sel] = 1'b1; end
        default: begin m_reg[sel] = '0;  m_vld[sel] = 1'b1; end
      endcase
      done_q.push_back('{acc + n + 1, m_reg, m_vld});
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((op_q.size() != 0 || done_q.size() != 0) && guard < 300) begin
      @(posedge clock);
      guard++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("op_queue_empty", op_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
  endtask

  initial begin
    int a0, a1, a2;
    logic [1:0] rop;
    // Reset state
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'b0, CmdReady}, 32'd0);
    chk("rst_E", {28'b0, E}, 32'd0);
    chk("rst_Done", {31'b0, Done}, 32'd0);
    chk("rst_FunSel", {30'b0, FunSel}, 32'd0);
    chk("rst_I", {16'b0, I}, 32'd0);
    chk("rst_ReadQ", {16'b0, ReadQ}, 32'd0);
    chk("rst_ShadowValid", {28'b0, ShadowValid}, 32'd0);
    @(posedge clock);
    #1;
    Reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {31'b0, CmdReady}, 32'd1);
    @(posedge clock);
    #1;

    // LOAD then readback
    send(2'b10, 2'd2, 4'd7, 16'hA5A5, -1, a0);
    // Wrap: FFFE + 4 = 0002
    send(2'b10, 2'd0, 4'd0, 16'hFFFE, -1, a0);
    send(2'b01, 2'd0, 4'd3, 16'h1234, -1, a0);
    // Underflow: 0 - 1 = FFFF, valid stays set
    send(2'b11, 2'd3, 4'd5, 16'h5555, -1, a0);
    send(2'b00, 2'd3, 4'd0, 16'h0000, -1, a0);
    drain();

    // Back-to-back single-op commands accept 2 cycles apart
    send(2'b10, 2'd0, 4'd0, 16'h1111, -1, a1);
    send(2'b10, 2'd1, 4'd0, 16'h2222, -1, a2);
    chk("b2b_spacing", a2 - a1, 2);
    drain();

    // Reset in the 3rd E cycle of INC x10: only 2 ops reach the bank
    send(2'b01, 2'd1, 4'd9, 16'h0, 2, a0);
    repeat (2) @(posedge clock);
    #1;
    Reset = 1'b1;
    @(negedge clock);
    chk("midrst_E_gated", {28'b0, E}, 32'd0);
    chk("midrst_ready", {31'b0, CmdReady}, 32'd0);
    @(posedge clock);
    #1;
    Reset = 1'b0;
    m_reg = '0;
    m_vld = '0;
    @(negedge clock);
    chk("after_rst_E", {28'b0, E}, 32'd0);
    chk("after_rst_ready", {31'b0, CmdReady}, 32'd1);
    @(posedge clock);
    #1;
    drain();

    // Randomized commands with random idle gaps
    for (int t = 0; t < 60; t++) begin
      rop = 2'($urandom);
      send(rop, 2'($urandom), 4'($urandom), 16'($urandom), -1, a0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $finish;
  end

endmodule
